// File: rtl/cr_fifo_pkg.sv
// Shared types and sizing for the cr_fifo read-side stage and its skid buffer.
// Holds the read-stage state encoding and skid depth/counter widths.
package cr_fifo_pkg;

    typedef enum logic [0:0] {
        RD_RUN   = 1'b0,
        RD_FLUSH = 1'b1
    } rd_stage_state_e;

    localparam int RD_SKID_DEPTH    = 2;
    localparam int RD_SKID_CNT_BITS = $clog2(RD_SKID_DEPTH + 1);
    localparam int RD_SKID_PTR_BITS = $clog2(RD_SKID_DEPTH);

endpackage

// File: rtl/cr_fifo_rd_skid.sv
// 2-entry register skid buffer: push writes at wr_ptr, pull advances rd_ptr, clr empties it.
// Latency: pushed word visible on data/vld the cycle after the push; caller must not push when full.
module cr_fifo_rd_skid
    import cr_fifo_pkg::*;
#(
    parameter int N_DATA_BITS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [N_DATA_BITS-1:0]      push_data,
    input  logic                        pull,
    input  logic                        clr,
    output logic [RD_SKID_CNT_BITS-1:0] cnt,
    output logic                        vld,
    output logic [N_DATA_BITS-1:0]      data
);

    logic [N_DATA_BITS-1:0]      mem_q [RD_SKID_DEPTH];
    logic [N_DATA_BITS-1:0]      mem_d [RD_SKID_DEPTH];
    logic [RD_SKID_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [RD_SKID_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [RD_SKID_CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Clear wins over a same-cycle push/pull; stored words are simply abandoned.
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pull) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + RD_SKID_CNT_BITS'(push) - RD_SKID_CNT_BITS'(pull);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign vld  = (cnt_q != '0);
    assign data = mem_q[rd_ptr_q];

endmodule

// File: rtl/cr_fifo_rd_stage.sv
// FIFO read stage: pops a FWFT FIFO into a registered valid/ready stream, with flush/drain and stats.
// Latency 1 cycle pop-to-out_vld; out_rdy low stops popping after 2 buffered words (no comb out_rdy path).
module cr_fifo_rd_stage
    import cr_fifo_pkg::*;
#(
    parameter int N_DATA_BITS    = 64,
    parameter int STALL_CNT_BITS = 16,
    parameter int XFER_CNT_BITS  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_DATA_BITS-1:0]    fifo_rdata,
    input  logic                      fifo_empty,
    output logic                      fifo_ren,
    output logic                      out_vld,
    output logic [N_DATA_BITS-1:0]    out_data,
    input  logic                      out_rdy,
    input  logic                      flush,
    output logic                      flush_busy,
    output logic                      flush_done,
    input  logic                      stall_clr,
    output logic [STALL_CNT_BITS-1:0] stall_cnt,
    output logic [XFER_CNT_BITS-1:0]  xfer_cnt
);

    rd_stage_state_e             state_q, state_d;
    logic [STALL_CNT_BITS-1:0]   stall_cnt_q, stall_cnt_d;
    logic [XFER_CNT_BITS-1:0]    xfer_cnt_q, xfer_cnt_d;

    logic [RD_SKID_CNT_BITS-1:0] skid_cnt;
    logic                        skid_vld;
    logic                        skid_push;
    logic                        skid_clr;
    logic                        ren_raw;
    logic                        xfer_hs;

    assign xfer_hs = skid_vld & out_rdy;

    always_comb begin
        state_d    = state_q;
        ren_raw    = 1'b0;
        skid_push  = 1'b0;
        skid_clr   = 1'b0;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            RD_RUN: begin
                // Gated by the registered occupancy only, so out_rdy never reaches fifo_ren.
                ren_raw   = ~fifo_empty & (skid_cnt < RD_SKID_CNT_BITS'(RD_SKID_DEPTH));
                skid_push = ren_raw;
                if (flush) begin
                    state_d  = RD_FLUSH;
                    skid_clr = 1'b1;
                end
            end
            RD_FLUSH: begin
                flush_busy = 1'b1;
                ren_raw    = ~fifo_empty;
                if (fifo_empty) begin
                    flush_done = 1'b1;
                    state_d    = RD_RUN;
                end
            end
            default: state_d = RD_RUN;
        endcase
    end

    assign fifo_ren = ren_raw & rst_n;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (skid_vld && !out_rdy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_BITS'(1);
        end
        if (xfer_hs) begin
            xfer_cnt_d = xfer_cnt_q + XFER_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_RUN;
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    cr_fifo_rd_skid #(
        .N_DATA_BITS (N_DATA_BITS)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (skid_push),
        .push_data (fifo_rdata),
        .pull      (xfer_hs),
        .clr       (skid_clr),
        .cnt       (skid_cnt),
        .vld       (skid_vld),
        .data      (out_data)
    );

    assign out_vld   = skid_vld;
    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_cr_fifo_rd_stage.sv
// Bench for cr_fifo_rd_stage: FIFO model plus word-queue reference, directed phases then random traffic.
module tb_cr_fifo_rd_stage;

    localparam int DW    = 64;
    localparam int SB    = 4;
    localparam int XB    = 8;
    localparam int SMAX  = (1 << SB) - 1;
    localparam int XMOD  = (1 << XB);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          fifo_ren;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy;
    logic          flush;
    logic          flush_busy;
    logic          flush_done;
    logic          stall_clr;
    logic [SB-1:0] stall_cnt;
    logic [XB-1:0] xfer_cnt;

    always #5 clk = ~clk;

    cr_fifo_rd_stage #(
        .N_DATA_BITS    (DW),
        .STALL_CNT_BITS (SB),
        .XFER_CNT_BITS  (XB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_rdy    (out_rdy),
        .flush      (flush),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt),
        .xfer_cnt   (xfer_cnt)
    );

    logic [DW-1:0] fq [$];
    logic [DW-1:0] exp_q [$];
    bit            pop_pending = 1'b0;
    int            pop_total = 0;
    int            done_total = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            m_flushing = 1'b0;
    int            stall_m = 0;
    int            xfer_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fq[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        refresh();
    endtask

    // Apply the pop observed in the previous cycle just after the edge, then return at the negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending) void'(fq.pop_front());
        refresh();
        @(negedge clk);
    endtask

    // Monitor / scoreboard: exp_q holds words popped and still owed to the consumer.
    initial begin
        bit empty_now, ren_exp, vld_exp, hs;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                m_flushing = 1'b0;
                stall_m    = 0;
                xfer_m     = 0;
            end
            empty_now = (fq.size() == 0);
            ren_exp   = rst_n && !empty_now && (m_flushing || exp_q.size() < 2);
            vld_exp   = !m_flushing && (exp_q.size() != 0);
            chk("fifo_ren", 64'(fifo_ren), 64'(ren_exp));
            chk("out_vld", 64'(out_vld), 64'(vld_exp));
            if (vld_exp) chk("out_data", out_data, exp_q[0]);
            chk("flush_busy", 64'(flush_busy), 64'(m_flushing));
            chk("flush_done", 64'(flush_done), 64'(m_flushing && empty_now));
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            chk("xfer_cnt", 64'(xfer_cnt), 64'(xfer_m % XMOD));
            pop_pending = fifo_ren && !fifo_empty;
            if (pop_pending) pop_total++;
            if (flush_done) done_total++;
            if (rst_n) begin
                hs = vld_exp && out_rdy;
                if (stall_clr) stall_m = 0;
                else if (vld_exp && !out_rdy && stall_m < SMAX) stall_m++;
                if (hs) xfer_m = (xfer_m + 1) % XMOD;
                if (m_flushing) begin
                    if (empty_now) m_flushing = 1'b0;
                end else begin
                    if (hs) void'(exp_q.pop_front());
                    if (flush) begin
                        exp_q.delete();
                        m_flushing = 1'b1;
                    end else if (ren_exp) begin
                        exp_q.push_back(fq[0]);
                    end
                end
            end
        end
    end

    initial begin
        int p0, d0, x0;
        rst_n     = 1'b0;
        out_rdy   = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        refresh();

        // Reset with a loaded FIFO: nothing may be popped.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        tick();
        tick();
        #3;
        chk("rst_fifo_ren", 64'(fifo_ren), 64'(0));
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_flush_busy", 64'(flush_busy), 64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;

        // Streaming 8 words.
        repeat (12) tick();
        #3;
        chk("stream_xfer_cnt", 64'(xfer_cnt), 64'(8));

        // Back-pressure: only two words leave the FIFO.
        tick();
        out_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        p0 = pop_total;
        repeat (10) tick();
        #3;
        chk("bp_pops", 64'(pop_total - p0), 64'(2));
        chk("bp_hold_data", out_data, 64'(1));
        chk("bp_hold_vld", 64'(out_vld), 64'(1));
        tick();
        out_rdy = 1'b1;
        repeat (8) tick();

        // Stall counter saturation, then clear during a stall.
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        out_rdy   = 1'b0;
        push(64'hA1);
        push(64'hA2);
        repeat (22) tick();
        #3;
        chk("stall_saturated", 64'(stall_cnt), 64'(SMAX));
        tick();
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        #3;
        chk("stall_cleared", 64'(stall_cnt), 64'(0));
        tick();
        out_rdy = 1'b1;
        repeat (4) tick();

        // Flush with a full skid and four words still queued.
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push(64'hB0 + 64'(i));
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        d0 = done_total;
        repeat (10) tick();
        #3;
        chk("flush_done_pulses", 64'(done_total - d0), 64'(1));
        chk("flush_fifo_drained", 64'(fq.size()), 64'(0));
        tick();
        out_rdy = 1'b1;
        repeat (3) tick();

        // Handshake in the flush cycle is counted, the other skid word is dropped.
        out_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) push(64'hC0 + 64'(i));
        repeat (4) tick();
        x0      = xfer_m;
        out_rdy = 1'b1;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) tick();
        #3;
        chk("flush_hs_xfer", 64'(xfer_cnt), 64'((x0 + 1) % XMOD));

        // Reset in the middle of a drain, then resume.
        tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push(64'hD0 + 64'(i));
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_fifo_ren", 64'(fifo_ren), 64'(0));
        chk("rstmid_out_vld", 64'(out_vld), 64'(0));
        chk("rstmid_flush_busy", 64'(flush_busy), 64'(0));
        tick();
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        repeat (8) tick();
        #3;
        chk("rstmid_resume_xfer", 64'(xfer_cnt), 64'(3));

        // Random traffic.
        repeat (3000) begin
            tick();
            out_rdy   = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 79) == 0);
            stall_clr = ($urandom_range(0, 49) == 0);
            if (fq.size() < 6 && $urandom_range(0, 2) != 0) push({$urandom, $urandom});
        end
        flush     = 1'b0;
        stall_clr = 1'b0;
        out_rdy   = 1'b1;
        repeat (20) tick();
        #3;
        chk("final_idle_vld", 64'(out_vld), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
